dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory. It arbitrates round-robin between the CPU load/store port (m0) and the DMA/debug port (m1). Each granted request is issued to the memory as one registered read or write command, and read data is returned to the issuing port with a fixed latency. It sits between the core/DMA and the data memory, and is the memory's sole driver.

## Interface
Parameters:
- WIDTH, 32, data word width
- ADDR_W, 9, word-address width (512-word memory)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- mX_req  input  1  request, X∈{0,1}; held with payload until granted
- mX_we  input  1  1=write, 0=read
- mX_addr  input  ADDR_W  word address
- mX_wdata  input  WIDTH  write data
- mX_gnt  output  1  one-cycle pulse: request accepted this cycle
- mX_rvalid  output  1  one-cycle pulse: mX_rdata valid
- mX_rdata  output  WIDTH  read return data
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  WIDTH  memory write data
- mem_rdata  input  WIDTH  memory read data; valid the cycle after mem_read

## Operation
- Arbitration:
  - Combinational, in the same cycle as req.
  - Only one requester: it is granted.
  - Both requesting: the port not granted most recently is granted.
  - Pointer `last` updates on each grant and resets to 1, so m0 wins the first tie.
- mX_gnt is asserted only when mX_req=1. At most one gnt per cycle.
- Issue stage, registered:
  - On a grant, the next cycle drives mem_read=~we, mem_write=we, mem_addr, mem_wdata from the winner's payload.
  - Stores tag = port id and is_read.
  - With no grant, mem_read=mem_write=0; addr/wdata hold their last values.
- Return stage:
  - In the cycle after mem_read, mem_rdata is captured into a return register.
  - The cycle after capture, rvalid pulses to the tagged port only.
  - mX_rdata holds its value until the next rvalid to that port.
- Writes produce no rvalid.
- Ordering:
  - Commands issue in grant order; returns arrive in issue order.
  - A read after a write to the same address, granted later, observes the new data, because the memory write completes at the issue edge.
- Addresses are ADDR_W bits; no range check, no wrap logic.
- No backpressure from memory: one command per cycle sustained.

## Timing
- Reset values: all gnt, rvalid, mem_read, mem_write = 0; mem_addr, mem_wdata, mX_rdata = 0; `last`=1; all pipeline valids = 0.
- Request in cycle N with grant in N:
  - mem strobe in N+1.
  - mem_rdata in N+2.
  - mX_rvalid in N+3.
- Read latency is fixed at 3 cycles from gnt to rvalid.
- Back-to-back requests from both ports alternate every cycle, m0,m1,m0,…; throughput is 1 access/cycle total.
- A requester holding req across a grant is regranted only if the other port is idle. The following cycle after gnt, the requester must either drop req or present a new payload.
- Reset mid-operation:
  - Asynchronous clear of all pipeline valids.
  - In-flight reads are discarded, no rvalid.
  - In-flight writes may or may not have committed.
- No stall state: the design is a three-stage valid pipeline (grant → issue → return) plus the 1-bit RR pointer.

## Structure
- Package dmem_pkg: WIDTH/ADDR_W defaults; port-id type (1 bit); issue-tag struct {valid, is_read, port}.
- Sub-module rr_arb2: 2-way round-robin arbiter. It takes req[1:0] and a grant-accept signal, and outputs one-hot gnt[1:0] plus winner id. It owns the `last` pointer.
- Top level holds the issue and return registers and the rdata demux.

## Test plan
- Reset, m0 read addr 5 with memory model preloaded mem[5]=5 → m0_gnt in cycle 0, mem_read=1 / mem_addr=5 in cycle 1, m0_rvalid=1 / m0_rdata=5 in cycle 3; m1_rvalid stays 0.
- m0 write addr 3 data 0xDEAD, then m0 read addr 3 next cycle → mem_write then mem_read consecutive; read returns 0xDEAD.
- m0 and m1 both hold read req from reset, 6 cycles, addrs 1/2 → grants m0,m1,m0,m1,m0,m1; rvalids alternate with rdata 1,2,1,2,…, each 3 cycles after its gnt.
- m1 continuous req, m0 single req mid-stream → m0 granted in its first cycle if `last`=m1, else the next cycle; never delayed more than 1 cycle.
- Reset asserted asynchronously (mid-cycle) between mem_read and rvalid → rvalid never asserted; all outputs 0 immediately; first grant after release goes to m0 on a tie.
- Write-only traffic on both ports for 10 cycles → 10 mem_write strobes, zero rvalid pulses.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 9;

  typedef logic port_id_t;

  typedef struct packed {
    logic     valid;
    logic     is_read;
    port_id_t port;
  } iss_tag_t;

  // On a tie the port that did not win last time goes next.
  function automatic port_id_t rr_pick(input logic [1:0] req, input port_id_t last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side request/grant/return bundle
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic              gnt;
  logic              rvalid;
  logic [WIDTH-1:0]  rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin arbiter owning the last-winner pointer
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output port_id_t   winner_o
);

  port_id_t last_q;
  port_id_t last_d;

  always_comb begin
    winner_o = rr_pick(req_i, last_q);
    gnt_o    = {req_i[1] & winner_o, req_i[0] & ~winner_o} & {2{accept_i}};
    last_d   = (|gnt_o) ? winner_o : last_q;
  end

  // Reset to m1 so that m0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - grant -> issue -> return pipeline driving the single-port data memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     m0_if,
  dmem_arbiter_if.slave     m1_if,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WIDTH-1:0]  mem_wdata_o,
  input  logic [WIDTH-1:0]  mem_rdata_i
);

  logic [1:0]        gnt;
  port_id_t          winner;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [WIDTH-1:0]  win_wdata;

  iss_tag_t          iss_d, iss_q;
  iss_tag_t          ret_d, ret_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [WIDTH-1:0]  wdata_d, wdata_q;
  logic [1:0]        rvalid_d, rvalid_q;
  logic [WIDTH-1:0]  rdata0_d, rdata0_q;
  logic [WIDTH-1:0]  rdata1_d, rdata1_q;

  // Grants are forced low while reset is asserted so outputs clear at once.
  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({m1_if.req, m0_if.req}),
    .accept_i (rst_n),
    .gnt_o    (gnt),
    .winner_o (winner)
  );

  always_comb begin
    win_we    = winner ? m1_if.we    : m0_if.we;
    win_addr  = winner ? m1_if.addr  : m0_if.addr;
    win_wdata = winner ? m1_if.wdata : m0_if.wdata;

    iss_d   = '{valid: |gnt, is_read: ~win_we, port: winner};
    addr_d  = (|gnt) ? win_addr  : addr_q;
    wdata_d = (|gnt) ? win_wdata : wdata_q;

    ret_d    = iss_q;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // Memory data for a read issued last cycle is on mem_rdata_i now.
    if (ret_q.valid && ret_q.is_read) begin
      if (ret_q.port) begin
        rvalid_d[1] = 1'b1;
        rdata1_d    = mem_rdata_i;
      end else begin
        rvalid_d[0] = 1'b1;
        rdata0_d    = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q    <= '0;
      ret_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      iss_q    <= iss_d;
      ret_q    <= ret_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mem_read_o   = iss_q.valid &  iss_q.is_read;
  assign mem_write_o  = iss_q.valid & ~iss_q.is_read;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;

  assign m0_if.gnt    = gnt[0];
  assign m1_if.gnt    = gnt[1];
  assign m0_if.rvalid = rvalid_q[0];
  assign m1_if.rvalid = rvalid_q[1];
  assign m0_if.rdata  = rdata0_q;
  assign m1_if.rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int W  = 32;
  localparam int AW = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.WIDTH(W), .ADDR_W(AW)) m0_if ();
  dmem_arbiter_if #(.WIDTH(W), .ADDR_W(AW)) m1_if ();

  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;

  dmem_arbiter #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_if       (m0_if),
    .m1_if       (m1_if),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Memory model: unwritten words read back as their own address.
  bit [W-1:0] mem_arr [512];
  bit         mem_wr  [512];
  always @(posedge clk) begin
    if (mem_write) begin
      mem_arr[mem_addr] <= mem_wdata;
      mem_wr[mem_addr]  <= 1'b1;
    end
    if (mem_read) mem_rdata <= mem_wr[mem_addr] ? mem_arr[mem_addr] : W'(mem_addr);
  end

  typedef struct {int idle; logic we; logic [AW-1:0] addr; logic [W-1:0] wdata;} op_t;
  typedef struct {int due; logic we; logic [AW-1:0] addr; logic [W-1:0] wdata;} iss_exp_t;
  typedef struct {int due; logic [W-1:0] data;} ret_exp_t;

  op_t      ops0[$], ops1[$];
  iss_exp_t iss_sb[$];
  ret_exp_t ret0_sb[$], ret1_sb[$];
  bit [W-1:0] shadow [512];
  bit         sh_wr  [512];

  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int wr_cnt = 0, rv0_cnt = 0, rv1_cnt = 0;
  int gnt_log[$];
  port_id_t last_model = 1'b1;
  bit chk_delay = 1'b0;
  int gd[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_ret(input int p, input logic rv, input logic [W-1:0] rd);
    ret_exp_t e;
    int sz;
    sz = (p == 0) ? ret0_sb.size() : ret1_sb.size();
    if (rv) begin
      if (p == 0) rv0_cnt++; else rv1_cnt++;
      if (sz == 0) begin
        check_val(p == 0 ? "rvalid0_unexpected" : "rvalid1_unexpected", 32'(rv), 32'd0);
      end else begin
        e = (p == 0) ? ret0_sb.pop_front() : ret1_sb.pop_front();
        check_val(p == 0 ? "rvalid0_cycle" : "rvalid1_cycle", cyc, e.due);
        check_val(p == 0 ? "rdata0" : "rdata1", rd, e.data);
      end
    end else if (sz > 0) begin
      e = (p == 0) ? ret0_sb[0] : ret1_sb[0];
      if (e.due <= cyc) begin
        check_val(p == 0 ? "rvalid0_missing" : "rvalid1_missing", 32'd0, 32'd1);
        if (p == 0) void'(ret0_sb.pop_front()); else void'(ret1_sb.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      int p;
      iss_exp_t ie;
      ret_exp_t re;
      logic we;
      logic [AW-1:0] a;
      logic [W-1:0] wd;
      check_val("gnt_onehot", 32'(m0_if.gnt & m1_if.gnt), 32'd0);
      if (m0_if.gnt) check_val("gnt0_req", 32'(m0_if.req), 32'd1);
      if (m1_if.gnt) check_val("gnt1_req", 32'(m1_if.req), 32'd1);
      if (m0_if.gnt || m1_if.gnt) begin
        p  = m1_if.gnt ? 1 : 0;
        we = p ? m1_if.we    : m0_if.we;
        a  = p ? m1_if.addr  : m0_if.addr;
        wd = p ? m1_if.wdata : m0_if.wdata;
        gnt_log.push_back(p);
        last_model = port_id_t'(p);
        ie = '{cyc + 1, we, a, wd};
        iss_sb.push_back(ie);
        if (we) begin
          shadow[a] = wd;
          sh_wr[a]  = 1'b1;
        end else begin
          re = '{cyc + 3, sh_wr[a] ? shadow[a] : W'(a)};
          if (p == 0) ret0_sb.push_back(re); else ret1_sb.push_back(re);
        end
      end
      if (mem_read || mem_write) begin
        if (mem_write) wr_cnt++;
        if (iss_sb.size() == 0) begin
          check_val("issue_unexpected", 32'd1, 32'd0);
        end else begin
          ie = iss_sb.pop_front();
          check_val("issue_cycle", cyc, ie.due);
          check_val("issue_write", 32'(mem_write), 32'(ie.we));
          check_val("issue_read", 32'(mem_read), 32'(!ie.we));
          check_val("issue_addr", 32'(mem_addr), 32'(ie.addr));
          if (ie.we) check_val("issue_wdata", mem_wdata, ie.wdata);
        end
      end else if (iss_sb.size() > 0 && iss_sb[0].due <= cyc) begin
        check_val("issue_missing", 32'd0, 32'd1);
        void'(iss_sb.pop_front());
      end
      check_ret(0, m0_if.rvalid, m0_if.rdata);
      check_ret(1, m1_if.rvalid, m1_if.rdata);
    end
  end

  function automatic logic port_gnt(input int p);
    return (p == 0) ? m0_if.gnt : m1_if.gnt;
  endfunction

  task automatic drive(input int p, input logic r, input op_t op);
    if (p == 0) begin
      m0_if.req = r; m0_if.we = op.we; m0_if.addr = op.addr; m0_if.wdata = op.wdata;
    end else begin
      m1_if.req = r; m1_if.we = op.we; m1_if.addr = op.addr; m1_if.wdata = op.wdata;
    end
  endtask

  task automatic run_port(input int p);
    op_t op;
    int n, t, rq, exp_d;
    n = (p == 0) ? ops0.size() : ops1.size();
    for (int i = 0; i < n; i++) begin
      op = (p == 0) ? ops0[i] : ops1[i];
      if (op.idle > 0) begin
        drive(p, 1'b0, op);
        repeat (op.idle) begin @(posedge clk); #1; end
      end
      drive(p, 1'b1, op);
      rq    = cyc;
      exp_d = (m1_if.req && last_model == 1'b0) ? 1 : 0;
      t = 0;
      forever begin
        @(negedge clk);
        if (port_gnt(p)) break;
        t++;
        if (t >= 16) begin
          check_val("gnt_timeout", 32'(t), 32'd0);
          break;
        end
      end
      gd[p] = cyc - rq;
      if (p == 0 && chk_delay) check_val("m0_gnt_delay", 32'(gd[0]), 32'(exp_d));
      @(posedge clk); #1;
    end
    drive(p, 1'b0, '{0, 1'b0, '0, '0});
  endtask

  task automatic run_ops();
    fork
      run_port(0);
      run_port(1);
    join
    repeat (6) @(posedge clk);
    #1;
    ops0.delete();
    ops1.delete();
  endtask

  task automatic flush_model();
    iss_sb.delete();
    ret0_sb.delete();
    ret1_sb.delete();
    last_model = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, '{0, 1'b0, '0, '0});
    drive(1, 1'b0, '{0, 1'b0, '0, '0});
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_gnt", 32'({m1_if.gnt, m0_if.gnt}), 32'd0);
    check_val("rst_rvalid", 32'({m1_if.rvalid, m0_if.rvalid}), 32'd0);
    check_val("rst_mem_strobe", 32'({mem_read, mem_write}), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    check_val("rst_rdata0", m0_if.rdata, 32'd0);
    check_val("rst_rdata1", m1_if.rdata, 32'd0);
    rst_n = 1'b1;

    // single read of addr 5
    rv1_cnt = 0;
    ops0.push_back('{0, 1'b0, 9'd5, 32'd0});
    run_ops();
    check_val("t1_gnt_delay", 32'(gd[0]), 32'd0);
    check_val("t1_rdata0", m0_if.rdata, 32'd5);
    check_val("t1_m1_rvalid", 32'(rv1_cnt), 32'd0);

    // write then read same address
    ops0.push_back('{0, 1'b1, 9'd3, 32'hDEAD});
    ops0.push_back('{0, 1'b0, 9'd3, 32'd0});
    run_ops();
    check_val("t2_rdata0", m0_if.rdata, 32'hDEAD);

    // both ports contend from reset
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < 3; i++) begin
      ops0.push_back('{0, 1'b0, 9'd1, 32'd0});
      ops1.push_back('{0, 1'b0, 9'd2, 32'd0});
    end
    run_ops();
    check_val("t3_ngnt", 32'(gnt_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      check_val("t3_order", 32'(gnt_log[i]), 32'(i % 2));
    check_val("t3_rdata0", m0_if.rdata, 32'd1);
    check_val("t3_rdata1", m1_if.rdata, 32'd2);

    // m1 streams, m0 drops in once mid-stream
    chk_delay = 1'b1;
    for (int i = 0; i < 8; i++) ops1.push_back('{0, 1'b0, 9'(7 + i), 32'd0});
    ops0.push_back('{3, 1'b0, 9'd9, 32'd0});
    run_ops();
    chk_delay = 1'b0;
    check_val("t4_delay_bound", 32'(gd[0] <= 1), 32'd1);

    // asynchronous reset with a read in flight
    do_reset();
    @(posedge clk); #1;
    drive(0, 1'b1, '{0, 1'b0, 9'd11, 32'd0});
    @(negedge clk);
    check_val("t5_gnt0", 32'(m0_if.gnt), 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, '{0, 1'b0, 9'd11, 32'd0});
    check_val("t5_mem_read", 32'(mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_strobe", 32'({mem_read, mem_write}), 32'd0);
    check_val("t5_rst_addr", 32'(mem_addr), 32'd0);
    check_val("t5_rst_rvalid", 32'({m1_if.rvalid, m0_if.rvalid}), 32'd0);
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    rv0_cnt = 0;
    rv1_cnt = 0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("t5_no_rvalid", 32'(rv0_cnt + rv1_cnt), 32'd0);
    drive(0, 1'b1, '{0, 1'b0, 9'd1, 32'd0});
    drive(1, 1'b1, '{0, 1'b0, 9'd2, 32'd0});
    @(negedge clk);
    check_val("t5_tie_m0", 32'(m0_if.gnt), 32'd1);
    check_val("t5_tie_m1", 32'(m1_if.gnt), 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, '{0, 1'b0, 9'd1, 32'd0});
    @(negedge clk);
    check_val("t5_then_m1", 32'(m1_if.gnt), 32'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, '{0, 1'b0, 9'd2, 32'd0});
    repeat (6) @(posedge clk);
    #1;

    // write-only traffic
    wr_cnt  = 0;
    rv0_cnt = 0;
    rv1_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      ops0.push_back('{0, 1'b1, 9'(20 + i), 32'(32'hA000 + i)});
      ops1.push_back('{0, 1'b1, 9'(40 + i), 32'(32'hB000 + i)});
    end
    run_ops();
    check_val("t6_writes", 32'(wr_cnt), 32'd10);
    check_val("t6_rvalids", 32'(rv0_cnt + rv1_cnt), 32'd0);

    // read back one word from each port's writes
    ops0.push_back('{0, 1'b0, 9'd42, 32'd0});
    ops1.push_back('{0, 1'b0, 9'd21, 32'd0});
    run_ops();
    check_val("t7_rdata0", m0_if.rdata, 32'hB002);
    check_val("t7_rdata1", m1_if.rdata, 32'hA001);

    check_val("drain_issue", 32'(iss_sb.size()), 32'd0);
    check_val("drain_ret0", 32'(ret0_sb.size()), 32'd0);
    check_val("drain_ret1", 32'(ret1_sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
